// File: rtl/ping_pong_ctrl_w_if.sv
// Producer, bank-port and consumer signals of the west ping-pong buffer sequencer.
// Widths are derived here so both sides of the link always agree.
interface ping_pong_ctrl_w_if #(
  parameter int unsigned TOTAL_MODULES = 4,
  parameter int unsigned COL_X         = 16,
  parameter int unsigned TOTAL_INPUT_W = 2
);
  localparam int unsigned SEL_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
  localparam int unsigned ADDR_WIDTH = $clog2(COL_X * TOTAL_INPUT_W);

  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      slice_sel;
  logic [SEL_W-1:0]      slicing_idx;
  logic                  bank0_ena;
  logic                  bank0_enb;
  logic                  bank0_wea;
  logic                  bank0_web;
  logic [ADDR_WIDTH-1:0] bank0_addra;
  logic [ADDR_WIDTH-1:0] bank0_addrb;
  logic                  bank1_ena;
  logic                  bank1_enb;
  logic                  bank1_wea;
  logic                  bank1_web;
  logic [ADDR_WIDTH-1:0] bank1_addra;
  logic [ADDR_WIDTH-1:0] bank1_addrb;
  logic                  rd_req;
  logic                  rd_avail;
  logic                  rd_data_valid;
  logic                  rd_last;
  logic                  dout_sel;
  logic                  active_bank_wr;
  logic                  active_bank_rd;

  modport master (
    output in_valid, slice_sel, rd_req,
    input  in_ready, slicing_idx,
    input  bank0_ena, bank0_enb, bank0_wea, bank0_web, bank0_addra, bank0_addrb,
    input  bank1_ena, bank1_enb, bank1_wea, bank1_web, bank1_addra, bank1_addrb,
    input  rd_avail, rd_data_valid, rd_last, dout_sel, active_bank_wr, active_bank_rd
  );

  modport slave (
    input  in_valid, slice_sel, rd_req,
    output in_ready, slicing_idx,
    output bank0_ena, bank0_enb, bank0_wea, bank0_web, bank0_addra, bank0_addrb,
    output bank1_ena, bank1_enb, bank1_wea, bank1_web, bank1_addra, bank1_addrb,
    output rd_avail, rd_data_valid, rd_last, dout_sel, active_bank_wr, active_bank_rd
  );
endinterface

// File: rtl/ping_pong_ctrl_w.sv
// West ping-pong buffer sequencer: fills one bank two rows per beat while the
// other, full bank is swept in order through port A for RD_REPEAT passes.
module ping_pong_ctrl_w #(
  parameter int unsigned TOTAL_MODULES = 4,
  parameter int unsigned COL_X         = 16,
  parameter int unsigned TOTAL_INPUT_W = 2,
  parameter int unsigned RD_REPEAT     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ping_pong_ctrl_w_if.slave  pif
);
  localparam int unsigned SEL_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
  localparam int unsigned ADDR_WIDTH = $clog2(COL_X * TOTAL_INPUT_W);
  localparam int unsigned CNT_W      = (COL_X > 1) ? $clog2(COL_X) : 1;
  localparam int unsigned PASS_W     = (RD_REPEAT > 1) ? $clog2(RD_REPEAT) : 1;

  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic [CNT_W-1:0]      wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PASS_W-1:0]     rd_pass;
  logic [SEL_W-1:0]      slice_q;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  dout_sel_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_done;
  logic                  rd_wrap;
  logic                  rd_release;
  logic [ADDR_WIDTH-1:0] wr_addra;
  logic [ADDR_WIDTH-1:0] wr_addrb;

  // Handshake qualification; rst_n gating keeps every strobe low while in reset.
  always_comb begin
    wr_fire    = rst_n && pif.in_valid && !full[wr_bank];
    rd_fire    = rst_n && pif.rd_req && full[rd_bank];
    wr_done    = wr_fire && (wr_cnt == CNT_W'(COL_X - 1));
    rd_wrap    = rd_fire && (rd_addr == ADDR_WIDTH'(2 * COL_X - 1));
    rd_release = rd_wrap && (rd_pass == PASS_W'(RD_REPEAT - 1));
    wr_addra   = ADDR_WIDTH'(wr_cnt);
    wr_addrb   = ADDR_WIDTH'(wr_cnt) + ADDR_WIDTH'(COL_X);
    full_nxt   = full;
    if (wr_done)    full_nxt[wr_bank] = 1'b1;
    if (rd_release) full_nxt[rd_bank] = 1'b0;
  end

  // Bank port drive: write owns both ports of wr_bank, read owns port A of rd_bank.
  always_comb begin
    pif.bank0_ena   = 1'b0;
    pif.bank0_enb   = 1'b0;
    pif.bank0_wea   = 1'b0;
    pif.bank0_web   = 1'b0;
    pif.bank0_addra = '0;
    pif.bank0_addrb = '0;
    pif.bank1_ena   = 1'b0;
    pif.bank1_enb   = 1'b0;
    pif.bank1_wea   = 1'b0;
    pif.bank1_web   = 1'b0;
    pif.bank1_addra = '0;
    pif.bank1_addrb = '0;
    if (rd_fire && !rd_bank) begin
      pif.bank0_ena   = 1'b1;
      pif.bank0_addra = rd_addr;
    end
    if (rd_fire && rd_bank) begin
      pif.bank1_ena   = 1'b1;
      pif.bank1_addra = rd_addr;
    end
    if (wr_fire && !wr_bank) begin
      pif.bank0_ena   = 1'b1;
      pif.bank0_enb   = 1'b1;
      pif.bank0_wea   = 1'b1;
      pif.bank0_web   = 1'b1;
      pif.bank0_addra = wr_addra;
      pif.bank0_addrb = wr_addrb;
    end
    if (wr_fire && wr_bank) begin
      pif.bank1_ena   = 1'b1;
      pif.bank1_enb   = 1'b1;
      pif.bank1_wea   = 1'b1;
      pif.bank1_web   = 1'b1;
      pif.bank1_addra = wr_addra;
      pif.bank1_addrb = wr_addrb;
    end
  end

  // First beat of a fill presents slice_sel live; later beats reuse the latched copy.
  always_comb begin
    pif.in_ready       = !full[wr_bank];
    pif.rd_avail       = full[rd_bank];
    pif.slicing_idx    = (wr_cnt == '0) ? pif.slice_sel : slice_q;
    pif.rd_data_valid  = rd_valid_q;
    pif.rd_last        = rd_last_q;
    pif.dout_sel       = dout_sel_q;
    pif.active_bank_wr = wr_bank;
    pif.active_bank_rd = rd_bank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= '0;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      rd_pass    <= '0;
      slice_q    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      dout_sel_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      full       <= full_nxt;
      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_release;
      if (wr_fire) begin
        if (wr_cnt == '0) slice_q <= pif.slice_sel;
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
      if (rd_fire) begin
        dout_sel_q <= rd_bank;
        rd_addr    <= rd_wrap ? '0 : rd_addr + ADDR_WIDTH'(1);
        if (rd_wrap) rd_pass <= rd_release ? '0 : rd_pass + PASS_W'(1);
        if (rd_release) rd_bank <= ~rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_ping_pong_ctrl_w.sv
// Directed bench for ping_pong_ctrl_w: a per-cycle reference model of bank
// ownership and counts, plus literal expectations for the key scenarios.
module tb_ping_pong_ctrl_w;
  localparam int unsigned TM     = 4;
  localparam int unsigned CX     = 4;
  localparam int unsigned RR     = 2;
  localparam int unsigned ROWS   = 2 * CX;
  localparam int unsigned TOT_RD = ROWS * RR;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ping_pong_ctrl_w_if #(.TOTAL_MODULES(TM), .COL_X(CX), .TOTAL_INPUT_W(2)) pif ();

  ping_pong_ctrl_w #(.TOTAL_MODULES(TM), .COL_X(CX), .TOTAL_INPUT_W(2), .RD_REPEAT(RR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       b_ena [2];
  logic       b_enb [2];
  logic       b_wea [2];
  logic       b_web [2];
  logic [2:0] b_addra [2];
  logic [2:0] b_addrb [2];
  assign b_ena[0] = pif.bank0_ena;     assign b_ena[1] = pif.bank1_ena;
  assign b_enb[0] = pif.bank0_enb;     assign b_enb[1] = pif.bank1_enb;
  assign b_wea[0] = pif.bank0_wea;     assign b_wea[1] = pif.bank1_wea;
  assign b_web[0] = pif.bank0_web;     assign b_web[1] = pif.bank1_web;
  assign b_addra[0] = pif.bank0_addra; assign b_addra[1] = pif.bank1_addra;
  assign b_addrb[0] = pif.bank0_addrb; assign b_addrb[1] = pif.bank1_addrb;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which bank is being filled/drained and how far along.
  bit m_full [2];
  int m_wr, m_rd, m_wcnt, m_ridx, m_slice, m_dsel;
  bit m_vld, m_last;

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wr = 0; m_rd = 0; m_wcnt = 0; m_ridx = 0; m_slice = 0;
    m_dsel = 0; m_vld = 0; m_last = 0;
  endtask

  task automatic model_compare();
    bit wf, rf;
    int ea, eb;
    wf = pif.in_valid && !m_full[m_wr];
    rf = pif.rd_req && m_full[m_rd];
    chk("in_ready", pif.in_ready, int'(!m_full[m_wr]));
    chk("rd_avail", pif.rd_avail, int'(m_full[m_rd]));
    chk("active_bank_wr", pif.active_bank_wr, m_wr);
    chk("active_bank_rd", pif.active_bank_rd, m_rd);
    chk("rd_data_valid", pif.rd_data_valid, int'(m_vld));
    chk("rd_last", pif.rd_last, int'(m_last));
    if (m_vld) chk("dout_sel", pif.dout_sel, m_dsel);
    chk("slicing_idx", pif.slicing_idx, (m_wcnt == 0) ? int'(pif.slice_sel) : m_slice);
    for (int b = 0; b < 2; b++) begin
      bit w, r;
      w  = wf && (m_wr == b);
      r  = rf && (m_rd == b);
      ea = w ? m_wcnt : (r ? m_ridx % ROWS : 0);
      eb = w ? m_wcnt + CX : 0;
      chk($sformatf("bank%0d_ena", b), b_ena[b], int'(w || r));
      chk($sformatf("bank%0d_enb", b), b_enb[b], int'(w));
      chk($sformatf("bank%0d_wea", b), b_wea[b], int'(w));
      chk($sformatf("bank%0d_web", b), b_web[b], int'(w));
      chk($sformatf("bank%0d_addra", b), b_addra[b], ea);
      chk($sformatf("bank%0d_addrb", b), b_addrb[b], eb);
    end
  endtask

  task automatic model_step();
    bit wf, rf;
    int wb, rb;
    wf = pif.in_valid && !m_full[m_wr];
    rf = pif.rd_req && m_full[m_rd];
    wb = m_wr;
    rb = m_rd;
    m_vld  = rf;
    m_last = rf && (m_ridx == TOT_RD - 1);
    if (rf) m_dsel = rb;
    if (wf) begin
      if (m_wcnt == 0) m_slice = int'(pif.slice_sel);
      if (m_wcnt == CX - 1) begin
        m_full[wb] = 1; m_wcnt = 0; m_wr = 1 - wb;
      end else m_wcnt++;
    end
    if (rf) begin
      if (m_ridx == TOT_RD - 1) begin
        m_full[rb] = 0; m_ridx = 0; m_rd = 1 - rb;
      end else m_ridx++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset(); else model_compare();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
    end
  end

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pif.in_valid = 1'b0;
    pif.rd_req = 1'b0;
    pif.slice_sel = '0;
    #3;
    chk("rst_in_ready", pif.in_ready, 1);
    chk("rst_rd_avail", pif.rd_avail, 0);
    chk("rst_bank0_ena", pif.bank0_ena, 0);
    chk("rst_bank1_addrb", pif.bank1_addrb, 0);
    chk("rst_rd_data_valid", pif.rd_data_valid, 0);
    chk("rst_active_wr", pif.active_bank_wr, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    advance();

    // Fill bank0; slice_sel moves 2->3 mid-fill but the fill keeps slice 2.
    for (int k = 0; k < 4; k++) begin
      pif.in_valid = 1'b1;
      pif.slice_sel = (k < 2) ? 2'd2 : 2'd3;
      settle();
      chk("fill0_addra", pif.bank0_addra, k);
      chk("fill0_addrb", pif.bank0_addrb, k + 4);
      chk("fill0_slice", pif.slicing_idx, 2);
      chk("fill0_bank1_enb", pif.bank1_enb, 0);
      advance();
    end
    pif.in_valid = 1'b0;
    settle();
    chk("after_fill0_wr", pif.active_bank_wr, 1);
    chk("after_fill0_avail", pif.rd_avail, 1);
    advance();

    // Fill bank1; first beat shows the new slice 3 live.
    for (int k = 0; k < 4; k++) begin
      pif.in_valid = 1'b1;
      pif.slice_sel = (k == 0) ? 2'd3 : 2'd1;
      settle();
      chk("fill1_addra", pif.bank1_addra, k);
      chk("fill1_addrb", pif.bank1_addrb, k + 4);
      chk("fill1_slice", pif.slicing_idx, 3);
      chk("fill1_bank0_ena", pif.bank0_ena, 0);
      advance();
    end
    settle();
    chk("both_full_ready", pif.in_ready, 0);
    chk("both_full_ena1", pif.bank1_ena, 0);
    advance();

    // Two read sweeps of bank0 under write back-pressure.
    pif.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("sweep_addra", pif.bank0_addra, i % 8);
      chk("sweep_wea", pif.bank0_wea, 0);
      chk("sweep_ready", pif.in_ready, 0);
      if (i > 0) chk("sweep_valid", pif.rd_data_valid, 1);
      if (i > 0) chk("sweep_last", pif.rd_last, 0);
      advance();
    end
    settle();
    chk("release_last", pif.rd_last, 1);
    chk("release_dsel", pif.dout_sel, 0);
    chk("release_rd_bank", pif.active_bank_rd, 1);
    chk("release_ready", pif.in_ready, 1);
    chk("release_wr0", pif.bank0_wea, 1);
    chk("release_rd1_addra", pif.bank1_addra, 0);
    advance();

    // Advance bank1 sweep to rd_addr=5, then reset asynchronously mid-cycle.
    pif.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("pre_rst_addra", pif.bank1_addra, i + 1);
      advance();
    end
    pif.in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", pif.rd_data_valid, 0);
    chk("mid_rst_ready", pif.in_ready, 1);
    chk("mid_rst_avail", pif.rd_avail, 0);
    chk("mid_rst_ena1", pif.bank1_ena, 0);
    chk("mid_rst_ena0", pif.bank0_ena, 0);
    chk("mid_rst_addra1", pif.bank1_addra, 0);
    chk("mid_rst_rd_bank", pif.active_bank_rd, 0);
    pif.in_valid = 1'b0;
    pif.rd_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    settle();
    chk("post_rst_ready", pif.in_ready, 1);
    chk("post_rst_avail", pif.rd_avail, 0);
    advance();

    // Fill completion of bank1 lands on the same edge as bank0 release.
    pif.in_valid = 1'b1;
    pif.slice_sel = 2'd1;
    repeat (4) advance();
    pif.in_valid = 1'b0;
    pif.rd_req = 1'b1;
    repeat (12) advance();
    pif.in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      settle();
      chk("conc_wr1_addra", pif.bank1_addra, j);
      chk("conc_rd0_addra", pif.bank0_addra, 4 + j);
      advance();
    end
    pif.in_valid = 1'b0;
    pif.rd_req = 1'b0;
    settle();
    chk("conc_wr_bank", pif.active_bank_wr, 0);
    chk("conc_rd_bank", pif.active_bank_rd, 1);
    chk("conc_avail", pif.rd_avail, 1);
    chk("conc_ready", pif.in_ready, 1);
    chk("conc_last", pif.rd_last, 1);
    advance();

    // Mixed traffic pattern, checked by the model only.
    for (int i = 0; i < 150; i++) begin
      pif.in_valid = (i % 3) != 0;
      pif.rd_req = (i % 5) != 1;
      pif.slice_sel = 2'(i % 4);
      advance();
    end
    pif.in_valid = 1'b0;
    pif.rd_req = 1'b0;
    repeat (3) advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
